key_expand_seq: RTL and testbench

Sequential, parametrised AES key-schedule engine that expands one 128/192/256-bit cipher key into all round keys, producing one 32-bit schedule word per clock through a single shared `sub_word` instance. It replaces the fully unrolled combinational 128-bit key generator. Round keys are held in an internal word store and read back through a registered random-access port, feeding the encrypt and decrypt round datapaths. An optional reversed read order supports decryption.

---
 rtl/aes_pkg.sv | 52 +++++
 rtl/key_expand_seq_sub_word.sv | 11 +
 rtl/key_expand_seq.sv | 140 ++++++++++++++
 tb/tb_key_expand_seq.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants for the sequential key expander: S-box, round
// constants, expander FSM states and key-size helper functions.
package aes_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, DONE = 2'd2} kx_state_t;

  localparam logic [7:0] RCON [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic int nk_of(input int key_bits);
    return key_bits / 32'sd32;
  endfunction

  function automatic int nr_of(input int key_bits);
    return nk_of(key_bits) + 32'sd6;
  endfunction

  function automatic int nwords_of(input int key_bits);
    return 32'sd4 * (nr_of(key_bits) + 32'sd1);
  endfunction

  // Rcon pointer past the table end never reaches the datapath; return zero.
  function automatic logic [7:0] rcon_byte(input logic [3:0] idx);
    if (idx < 4'd10) return RCON[idx];
    else return 8'h00;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/key_expand_seq_sub_word.sv
// SubWord: four parallel S-box lookups applied bytewise to a 32-bit word.
module sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] subbed
);

  assign subbed = {SBOX[word[31:24]], SBOX[word[23:16]], SBOX[word[15:8]], SBOX[word[7:0]]};

endmodule

// File: rtl/key_expand_seq.sv
// Sequential AES key schedule: one 32-bit word per clock into a flop word store,
// read back as registered 128-bit round keys. KEYEXP_REVERSE_EN reverses read order.
module key_expand_seq
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                busy,
  output logic                done,
  output logic                keys_valid,
  input  logic [3:0]          rk_addr,
  output logic [127:0]        rk_out
);

  localparam int         NK       = nk_of(KEY_BITS);
  localparam int         NR       = nr_of(KEY_BITS);
  localparam int         NWORDS   = nwords_of(KEY_BITS);
  localparam logic [5:0] NK_IDX   = 6'(NK);
  localparam logic [5:0] LAST_IDX = 6'(NWORDS - 32'sd1);
  localparam logic [2:0] LAST_GRP = 3'(NK - 32'sd1);
  localparam logic [3:0] NR_IDX   = 4'(NR);
  localparam bit         MID_SUB  = (NK == 32'sd8);

  kx_state_t    state_r, state_nxt_s;
  logic [5:0]   idx_r;
  logic [2:0]   grp_r;
  logic [3:0]   rcon_ptr_r;
  logic [31:0]  words_r [NWORDS];
  logic         busy_r, done_r, keys_valid_r;
  logic [127:0] rk_r;

  logic [31:0]  prev_s, sub_in_s, sub_out_s, temp_s, new_word_s;
  logic [3:0]   rd_round_s;
  logic [5:0]   rd_base_s;
  logic         rd_ok_s;

  sub_word u_sub_word (
    .word   (sub_in_s),
    .subbed (sub_out_s)
  );

  // Schedule recurrence for word idx_r and next-state selection.
  always_comb begin
    state_nxt_s = state_r;
    prev_s      = words_r[idx_r - 6'd1];
    // grp_r == 0 marks i mod NK == 0; the single SubWord unit is shared by both cases.
    if (grp_r == 3'd0) sub_in_s = rot_word(prev_s);
    else sub_in_s = prev_s;
    if (grp_r == 3'd0) temp_s = sub_out_s ^ {rcon_byte(rcon_ptr_r), 24'h000000};
    else if (MID_SUB && (grp_r == 3'd4)) temp_s = sub_out_s;
    else temp_s = prev_s;
    new_word_s = words_r[idx_r - NK_IDX] ^ temp_s;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = EXPAND;
        else state_nxt_s = IDLE;
      end
      EXPAND: begin
        if (idx_r == LAST_IDX) state_nxt_s = DONE;
        else state_nxt_s = EXPAND;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state, word counters, status flags and the word store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      idx_r        <= 6'd0;
      grp_r        <= 3'd0;
      rcon_ptr_r   <= 4'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      keys_valid_r <= 1'b0;
      for (int k = 0; k < NWORDS; k++) words_r[k] <= 32'h0000_0000;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == EXPAND);
      done_r  <= (state_nxt_s == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            for (int k = 0; k < NK; k++) words_r[k] <= key_in[KEY_BITS-1-32*k -: 32];
            idx_r        <= NK_IDX;
            grp_r        <= 3'd0;
            rcon_ptr_r   <= 4'd0;
            keys_valid_r <= 1'b0;
          end
        end
        EXPAND: begin
          words_r[idx_r] <= new_word_s;
          idx_r          <= idx_r + 6'd1;
          if (grp_r == LAST_GRP) begin
            grp_r      <= 3'd0;
            rcon_ptr_r <= rcon_ptr_r + 4'd1;
          end else begin
            grp_r <= grp_r + 3'd1;
          end
          if (idx_r == LAST_IDX) keys_valid_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Map the requested address onto a stored round.
  always_comb begin
    rd_ok_s = (rk_addr <= NR_IDX);
`ifdef KEYEXP_REVERSE_EN
    rd_round_s = NR_IDX - rk_addr;
`else
    rd_round_s = rk_addr;
`endif
    rd_base_s = {rd_round_s, 2'b00};
  end

  // Registered round-key read; no stall while the store is being filled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rk_r <= 128'h0;
    end else if (rd_ok_s) begin
      rk_r <= {words_r[rd_base_s], words_r[rd_base_s + 6'd1],
               words_r[rd_base_s + 6'd2], words_r[rd_base_s + 6'd3]};
    end else begin
      rk_r <= 128'h0;
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign keys_valid = keys_valid_r;
  assign rk_out     = rk_r;

endmodule

// File: tb/tb_key_expand_seq.sv
// Self-checking bench for key_expand_seq: AES-128/192/256 instances, a
// FIPS-level schedule model with a cycle model of the AES-128 instance.
module tb_key_expand_seq;

  localparam logic [127:0] KEY_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] KEY_192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] KEY_256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
`ifdef KEYEXP_REVERSE_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic s128 = 1'b0, s192 = 1'b0, s256 = 1'b0;
  logic [127:0] k128 = '0;
  logic [191:0] k192 = '0;
  logic [255:0] k256 = '0;
  logic [3:0] a128 = '0, a192 = '0, a256 = '0;
  logic b128, d128, v128, b192, d192, v192, b256, d256, v256;
  logic [127:0] r128, r192, r256;

  key_expand_seq #(.KEY_BITS(128)) dut128 (.clk(clk), .rst(rst), .start(s128), .key_in(k128),
    .busy(b128), .done(d128), .keys_valid(v128), .rk_addr(a128), .rk_out(r128));
  key_expand_seq #(.KEY_BITS(192)) dut192 (.clk(clk), .rst(rst), .start(s192), .key_in(k192),
    .busy(b192), .done(d192), .keys_valid(v192), .rk_addr(a192), .rk_out(r192));
  key_expand_seq #(.KEY_BITS(256)) dut256 (.clk(clk), .rst(rst), .start(s256), .key_in(k256),
    .busy(b256), .done(d256), .keys_valid(v256), .rk_addr(a256), .rk_out(r256));

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;
  logic [7:0] sb [256];
  logic [7:0] rc [11];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // GF(2^8) arithmetic used to derive the S-box from its definition.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  task automatic init_tables();
    logic [7:0] inv;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
      sb[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rc[0] = 8'h00;
    rc[1] = 8'h01;
    for (int i = 2; i < 11; i++) rc[i] = xt(rc[i-1]);
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // Textbook key expansion; key is right-aligned in 256 bits.
  task automatic expand(input logic [255:0] key, input int nk, output logic [31:0] w [60]);
    logic [31:0] t;
    for (int j = 0; j < 60; j++) w[j] = 32'h0;
    for (int j = 0; j < nk; j++) w[j] = key[32*(nk-1-j) +: 32];
    for (int j = nk; j < 4*(nk+7); j++) begin
      t = w[j-1];
      if (j % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rc[j/nk], 24'h0};
      else if (nk == 8 && j % nk == 4) t = subw(t);
      w[j] = w[j-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] round_of(input logic [31:0] w [60], input int nr, input logic [3:0] a);
    int r;
    if (int'(a) > nr) return 128'h0;
    r = REV ? nr - int'(a) : int'(a);
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [3:0] addr_of(input int round, input int nr);
    return REV ? 4'(nr - round) : 4'(round);
  endfunction

  // Cycle model of the AES-128 instance: store contents, flags and read register.
  logic [31:0] m_store [60];
  logic [31:0] m_sched [60];
  bit m_run = 1'b0, m_done = 1'b0, m_valid = 1'b0;
  int m_k = 0;
  logic [127:0] m_rk = '0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      for (int j = 0; j < 60; j++) m_store[j] = 32'h0;
      m_run = 1'b0; m_done = 1'b0; m_valid = 1'b0; m_k = 0; m_rk = '0;
    end else begin
      m_rk = round_of(m_store, 10, a128);
      if (m_run) begin
        m_store[4+m_k] = m_sched[4+m_k];
        m_k++;
        if (4 + m_k == 44) begin
          m_run = 1'b0; m_done = 1'b1; m_valid = 1'b1;
        end
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (s128) begin
        expand({128'h0, k128}, 4, m_sched);
        for (int j = 0; j < 4; j++) m_store[j] = m_sched[j];
        m_run = 1'b1; m_k = 0; m_valid = 1'b0;
      end
    end
  end

  // Every-cycle comparison of the AES-128 instance against the model.
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("busy", b128, m_run);
      chk("done", d128, m_done);
      chk("keys_valid", v128, m_valid);
      chk("rk_out", r128, m_rk);
    end
  end

  task automatic wait_done(input int which, output int cyc);
    bit seen;
    cyc = 1;
    seen = 1'b0;
    while (cyc < 100 && !seen) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      seen = (which == 192) ? d192 : (which == 256) ? d256 : d128;
    end
  endtask

  task automatic rd(input int which, input logic [3:0] a, output logic [127:0] v);
    if (which == 192) a192 = a;
    else if (which == 256) a256 = a;
    else a128 = a;
    @(posedge clk);
    @(negedge clk);
    v = (which == 192) ? r192 : (which == 256) ? r256 : r128;
  endtask

  logic [31:0] w192 [60];
  logic [31:0] w256 [60];

  initial begin
    int cyc;
    bit seen;
    logic [127:0] v;
    init_tables();
    #1 rst = 1'b1;
    chk_on = 1'b1;
    repeat (2) @(negedge clk);
    chk("sbox[00]", sb[0], 8'h63);
    chk("sbox[53]", sb[8'h53], 8'hed);
    chk("rcon[10]", rc[10], 8'h36);
    chk("reset 192 flags", {b192, d192, v192}, 3'b000);
    chk("reset 192 rk", r192, 128'h0);
    chk("reset 256 flags", {b256, d256, v256}, 3'b000);
    rst = 1'b0;
    @(negedge clk);

    // AES-128 with a start pulse ignored at cycle 10 of the expansion.
    k128 = KEY_A; s128 = 1'b1;
    @(posedge clk); @(negedge clk);
    s128 = 1'b0;
    cyc = 1; seen = 1'b0;
    while (cyc < 100 && !seen) begin
      if (cyc == 10) begin k128 = KEY_B; s128 = 1'b1; end
      else s128 = 1'b0;
      @(posedge clk); cyc++;
      @(negedge clk); seen = d128;
    end
    s128 = 1'b0;
    chk("aes128 done latency", 128'(cyc), 128'd41);
    for (int a = 0; a < 16; a++) rd(128, 4'(a), v);
    rd(128, addr_of(1, 10), v);  chk("aes128 round1", v, 128'ha0fafe1788542cb123a339392a6c7605);
    rd(128, addr_of(10, 10), v); chk("aes128 round10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd(128, addr_of(0, 10), v);  chk("aes128 round0", v, KEY_A);
    rd(128, 4'd11, v);           chk("aes128 addr11", v, 128'h0);

    // Restart from IDLE with start held across DONE: re-taken on the next IDLE cycle.
    k128 = KEY_B; s128 = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("restart clears keys_valid", v128, 1'b0);
    wait_done(128, cyc);
    chk("restart done latency", 128'(cyc), 128'd41);
    @(posedge clk); @(negedge clk);
    chk("start ignored in DONE", b128, 1'b0);
    @(posedge clk); @(negedge clk);
    s128 = 1'b0;
    chk("start taken in IDLE", b128, 1'b1);
    wait_done(128, cyc);
    chk("back-to-back done latency", 128'(cyc), 128'd41);
    rd(128, addr_of(10, 10), v); chk("keyB round10", v, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    rd(128, addr_of(0, 10), v);  chk("keyB round0", v, KEY_B);

    // Reset at cycle 20 of an expansion.
    k128 = KEY_A; s128 = 1'b1;
    @(posedge clk); @(negedge clk);
    s128 = 1'b0;
    repeat (19) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid reset flags", {b128, d128, v128}, 3'b000);
    chk("mid reset rk", r128, 128'h0);
    @(negedge clk);
    a128 = 4'd0;
    @(posedge clk); @(negedge clk);
    chk("rk during reset", r128, 128'h0);
    rst = 1'b0;
    rd(128, 4'd0, v); chk("addr0 after reset", v, 128'h0);

    // AES-192.
    k192 = KEY_192; s192 = 1'b1;
    @(posedge clk); @(negedge clk);
    s192 = 1'b0;
    wait_done(192, cyc);
    chk("aes192 done latency", 128'(cyc), 128'd47);
    @(negedge clk);
    chk("aes192 keys_valid", v192, 1'b1);
    expand({64'h0, KEY_192}, 6, w192);
    for (int a = 0; a < 16; a++) begin
      rd(192, 4'(a), v);
      chk($sformatf("aes192 addr%0d", a), v, round_of(w192, 12, 4'(a)));
    end
    rd(192, addr_of(12, 12), v); chk("aes192 round12", v, 128'he98ba06f448c773c8ecc720401002202);

    // AES-256.
    k256 = KEY_256; s256 = 1'b1;
    @(posedge clk); @(negedge clk);
    s256 = 1'b0;
    wait_done(256, cyc);
    chk("aes256 done latency", 128'(cyc), 128'd53);
    expand(KEY_256, 8, w256);
    for (int a = 0; a < 16; a++) begin
      rd(256, 4'(a), v);
      chk($sformatf("aes256 addr%0d", a), v, round_of(w256, 14, 4'(a)));
    end
    rd(256, addr_of(14, 14), v); chk("aes256 round14", v, 128'hfe4890d1e6188d0b046df344706c631e);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
